alu_seq: RTL and testbench

Multi-word arithmetic sequencer for the 16-bit ALU. It accepts one request for an operation on 1..WORDS_MAX 16-bit words and fetches operand words low-to-high. It drives the ALU once per word, chaining carry through ADC/SBB, and streams result words back. On completion it reports merged multi-precision flags. It sits between the execute stage and the shared ALU, owning the ALU while busy.

---
 rtl/alu_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-word arithmetic sequencer driving a shared 16-bit ALU once per word, chaining carry.
// Define ALU_SEQ_DAA_EN to add the single-word decimal-adjust mode 8 and its ALU ports.
module alu_seq #(
    parameter int WORDS_MAX = 4,
    parameter int IDXW      = 3
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_mode,
    input  logic [IDXW-1:0] req_words,
    input  logic [11:0]     req_flags,
    output logic [IDXW-1:0] op_index,
    input  logic [15:0]     op1_in,
    input  logic [15:0]     op2_in,
    output logic [3:0]      alu_mode,
    output logic            alu_isize,
    output logic [15:0]     alu_op1,
    output logic [15:0]     alu_op2,
    output logic [11:0]     alu_flags,
    input  logic [15:0]     alu_result,
    input  logic [11:0]     alu_flags_o,
`ifdef ALU_SEQ_DAA_EN
    input  logic [7:0]      alu_daa_r,
    input  logic [11:0]     alu_daa_flags,
`endif
    output logic            wr_valid,
    output logic [IDXW-1:0] wr_index,
    output logic [15:0]     wr_data,
    output logic            done_valid,
    output logic [11:0]     done_flags,
    output logic            done_err
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [3:0]      mode_q, mode_d;
    logic [IDXW-1:0] last_q, last_d, idx_q, idx_d, wr_index_q, wr_index_d, last_n;
    logic [11:0]     flags_q, flags_d, done_flags_q, done_flags_d;
    logic [15:0]     wr_data_q, wr_data_d;
    logic carry_q, carry_d, zacc_q, zacc_d, af_q, af_d, pf_q, pf_d, err_q, err_d;
    logic wr_valid_q, wr_valid_d, done_valid_q, done_valid_d, done_err_q, done_err_d;
    logic run, daa, first, af0, pf0, err_req;
    logic [3:0]  chain_mode;
    logic [7:0]  daa_r;
    logic [11:0] daa_flags;
`ifdef ALU_SEQ_DAA_EN
    localparam bit DAA_EN = 1'b1;
    assign daa_r     = alu_daa_r;
    assign daa_flags = alu_daa_flags;
`else
    localparam bit DAA_EN = 1'b0;
    assign daa_r     = '0;
    assign daa_flags = '0;
`endif
    assign wr_valid   = wr_valid_q;
    assign wr_index   = wr_index_q;
    assign wr_data    = wr_data_q;
    assign done_valid = done_valid_q;
    assign done_flags = done_flags_q;
    assign done_err   = done_err_q;
    assign alu_isize  = 1'b1;
    always_comb begin
        req_ready  = state_q == IDLE;
        run        = state_q == RUN && !err_q;
        daa        = DAA_EN && mode_q == 4'd8;
        first      = idx_q == '0;
        af0        = first ? alu_flags_o[4] : af_q;
        pf0        = first ? alu_flags_o[2] : pf_q;
        err_req    = req_mode[3] && !(DAA_EN && req_mode == 4'd8);
        // Upper words continue the chain: ADD becomes ADC, SUB/CMP become SBB.
        chain_mode = (mode_q == 4'd0) ? 4'd2 : (mode_q == 4'd5 || mode_q == 4'd7) ? 4'd3 : mode_q;
        last_n     = (req_words == '0) ? '0 :
                     ({1'b0, req_words} > (IDXW+1)'(WORDS_MAX)) ? IDXW'(WORDS_MAX - 1) : req_words - 1'b1;
        op_index   = run ? idx_q : '0;
        alu_op1    = run ? op1_in : '0;
        alu_op2    = run ? op2_in : '0;
        alu_mode   = (!run || daa) ? 4'd0 : first ? mode_q : chain_mode;
        alu_flags  = !run ? 12'd0 : first ? flags_q : {flags_q[11:1], carry_q};
        state_d      = state_q;
        mode_d       = mode_q;
        last_d       = last_q;
        idx_d        = idx_q;
        flags_d      = flags_q;
        carry_d      = carry_q;
        zacc_d       = zacc_q;
        af_d         = af_q;
        pf_d         = pf_q;
        err_d        = err_q;
        wr_valid_d   = 1'b0;
        wr_index_d   = wr_index_q;
        wr_data_d    = wr_data_q;
        done_valid_d = 1'b0;
        done_flags_d = done_flags_q;
        done_err_d   = done_err_q;
        if (req_valid && req_ready) begin
            state_d = RUN;
            mode_d  = req_mode;
            flags_d = req_flags;
            idx_d   = '0;
            zacc_d  = 1'b1;
            err_d   = err_req;
            last_d  = (DAA_EN && req_mode == 4'd8) ? '0 : last_n;
        end else if (state_q == RUN && err_q) begin
            state_d      = IDLE;
            err_d        = 1'b0;
            done_valid_d = 1'b1;
            done_err_d   = 1'b1;
            done_flags_d = flags_q;
        end else if (run) begin
            carry_d = alu_flags_o[0];
            zacc_d  = zacc_q & alu_flags_o[6];
            af_d    = af0;
            pf_d    = pf0;
            idx_d   = idx_q + 1'b1;
            if (mode_q != 4'd7) begin
                wr_valid_d = 1'b1;
                wr_index_d = idx_q;
                wr_data_d  = daa ? {op1_in[15:8], daa_r} : alu_result;
            end
            if (idx_q == last_q) begin
                state_d      = IDLE;
                done_valid_d = 1'b1;
                done_err_d   = 1'b0;
                done_flags_d = daa ? daa_flags :
                               {alu_flags_o[11:7], zacc_q & alu_flags_o[6], alu_flags_o[5], af0,
                                alu_flags_o[3], pf0, alu_flags_o[1:0]};
            end
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mode_q       <= '0;
            last_q       <= '0;
            idx_q        <= '0;
            flags_q      <= '0;
            carry_q      <= 1'b0;
            zacc_q       <= 1'b0;
            af_q         <= 1'b0;
            pf_q         <= 1'b0;
            err_q        <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_index_q   <= '0;
            wr_data_q    <= '0;
            done_valid_q <= 1'b0;
            done_flags_q <= '0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            flags_q      <= flags_d;
            carry_q      <= carry_d;
            zacc_q       <= zacc_d;
            af_q         <= af_d;
            pf_q         <= pf_d;
            err_q        <= err_d;
            wr_valid_q   <= wr_valid_d;
            wr_index_q   <= wr_index_d;
            wr_data_q    <= wr_data_d;
            done_valid_q <= done_valid_d;
            done_flags_q <= done_flags_d;
            done_err_q   <= done_err_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with a behavioural 16-bit ALU attached.
module tb_alu_seq;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_mode = '0;
    logic [2:0]  req_words = '0;
    logic [11:0] req_flags = '0;
    logic [2:0]  op_index;
    logic [15:0] op1_in, op2_in;
    logic [3:0]  alu_mode;
    logic        alu_isize;
    logic [15:0] alu_op1, alu_op2, alu_result;
    logic [11:0] alu_flags, alu_flags_o;
    logic        wr_valid;
    logic [2:0]  wr_index;
    logic [15:0] wr_data;
    logic        done_valid;
    logic [11:0] done_flags;
    logic        done_err;
`ifdef ALU_SEQ_DAA_EN
    logic [7:0]  alu_daa_r = 8'h15;
    logic [11:0] alu_daa_flags = 12'h095;
`endif

    alu_seq #(.WORDS_MAX(4), .IDXW(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_words(req_words), .req_flags(req_flags),
        .op_index(op_index), .op1_in(op1_in), .op2_in(op2_in),
        .alu_mode(alu_mode), .alu_isize(alu_isize), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_flags(alu_flags), .alu_result(alu_result), .alu_flags_o(alu_flags_o),
`ifdef ALU_SEQ_DAA_EN
        .alu_daa_r(alu_daa_r), .alu_daa_flags(alu_daa_flags),
`endif
        .wr_valid(wr_valid), .wr_index(wr_index), .wr_data(wr_data),
        .done_valid(done_valid), .done_flags(done_flags), .done_err(done_err)
    );

    always #5 clock = ~clock;

    logic [15:0] a_w [8];
    logic [15:0] b_w [8];
    assign op1_in = a_w[op_index];
    assign op2_in = b_w[op_index];

    // Reference ALU: x86-style flags CF=0 PF=2 AF=4 ZF=6 SF=7 OF=11, other bits pass through.
    logic [16:0] r17;
    logic [15:0] axr;
    logic        cin, arith;
    always_comb begin
        cin   = (alu_mode == 4'd2 || alu_mode == 4'd3) ? alu_flags[0] : 1'b0;
        arith = 1'b0;
        r17   = '0;
        case (alu_mode)
            4'd0, 4'd2: begin r17 = {1'b0, alu_op1} + {1'b0, alu_op2} + {16'd0, cin}; arith = 1'b1; end
            4'd3, 4'd5, 4'd7: begin r17 = {1'b0, alu_op1} - {1'b0, alu_op2} - {16'd0, cin}; arith = 1'b1; end
            4'd1: r17 = {1'b0, alu_op1 | alu_op2};
            4'd4: r17 = {1'b0, alu_op1 & alu_op2};
            4'd6: r17 = {1'b0, alu_op1 ^ alu_op2};
            default: r17 = '0;
        endcase
        axr            = alu_op1 ^ alu_op2 ^ r17[15:0];
        alu_result     = r17[15:0];
        alu_flags_o    = alu_flags;
        alu_flags_o[0] = arith & r17[16];
        alu_flags_o[2] = ~^r17[7:0];
        alu_flags_o[4] = arith & axr[4];
        alu_flags_o[6] = r17[15:0] == 16'd0;
        alu_flags_o[7] = r17[15];
        alu_flags_o[11] = !arith ? 1'b0 :
                          (alu_mode == 4'd0 || alu_mode == 4'd2) ? (alu_op1[15] == alu_op2[15] && r17[15] != alu_op1[15]) :
                          (alu_op1[15] != alu_op2[15] && r17[15] != alu_op1[15]);
    end

    typedef struct {
        bit          done;
        logic [2:0]  idx;
        logic [15:0] data;
        logic [11:0] flags;
        bit          err;
    } exp_t;
    exp_t sb[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic exp_wr(input logic [2:0] i, input logic [15:0] d);
        sb.push_back('{done: 1'b0, idx: i, data: d, flags: 12'd0, err: 1'b0});
    endtask

    task automatic exp_done(input logic [11:0] f, input bit e);
        sb.push_back('{done: 1'b1, idx: 3'd0, data: 16'd0, flags: f, err: e});
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset_n && wr_valid) begin
            if (sb.size() == 0 || sb[0].done) chk("unexpected_wr", int'(wr_data), -1);
            else begin
                e = sb.pop_front();
                chk("wr_index", int'(wr_index), int'(e.idx));
                chk("wr_data", int'(wr_data), int'(e.data));
            end
        end
        if (reset_n && done_valid) begin
            if (sb.size() == 0 || !sb[0].done) chk("unexpected_done", int'(done_flags), -1);
            else begin
                e = sb.pop_front();
                chk("done_flags", int'(done_flags), int'(e.flags));
                chk("done_err", int'(done_err), int'(e.err));
            end
        end
    end

    task automatic run_req(input logic [3:0] m, input logic [2:0] w, input logic [11:0] f,
                           input int n, input logic [3:0] m0, input logic [3:0] m1);
        bit seen = 0;
        @(negedge clock);
        req_valid = 1'b1; req_mode = m; req_words = w; req_flags = f;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("ready_busy", int'(req_ready), 0);
        chk("mode_w0", int'(alu_mode), int'(m0));
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            if (c == 1 && n > 1) chk("mode_w1", int'(alu_mode), int'(m1));
            if (done_valid) begin
                chk("latency", c, n);
                chk("ready_after", int'(req_ready), 1);
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin a_w[i] = '0; b_w[i] = '0; end
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_wr_valid", int'(wr_valid), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_done_valid", int'(done_valid), 0);
        chk("rst_done_flags", int'(done_flags), 0);
        chk("rst_done_err", int'(done_err), 0);
        @(negedge clock); reset_n = 1'b1;

        a_w[0] = 16'hFFFF; a_w[1] = 16'h0001; b_w[0] = 16'h0001; b_w[1] = 16'h0000;
        exp_wr(0, 16'h0000); exp_wr(1, 16'h0002); exp_done(12'h014, 0);
        run_req(4'd0, 3'd2, 12'h001, 2, 4'd0, 4'd2);

        a_w[0] = 16'h0000; a_w[1] = 16'h0001; b_w[0] = 16'h0001; b_w[1] = 16'h0000;
        exp_wr(0, 16'hFFFF); exp_wr(1, 16'h0000); exp_done(12'h014, 0);
        run_req(4'd5, 3'd2, 12'h000, 2, 4'd5, 4'd3);

        for (int i = 0; i < 4; i++) begin a_w[i] = 16'h1234; b_w[i] = 16'h1234; end
        exp_done(12'h044, 0);
        run_req(4'd7, 3'd4, 12'h000, 4, 4'd7, 4'd3);

        exp_done(12'hA5A, 1);
        run_req(4'd9, 3'd2, 12'hA5A, 1, 4'd0, 4'd0);

        a_w[0] = 16'h0003; b_w[0] = 16'h0004;
        exp_wr(0, 16'h0007); exp_done(12'h100, 0);
        run_req(4'd0, 3'd0, 12'h100, 1, 4'd0, 4'd0);

        for (int i = 0; i < 8; i++) begin a_w[i] = 16'h1111; b_w[i] = 16'h1111; end
        for (int i = 0; i < 4; i++) exp_wr(3'(i), 16'h2222);
        exp_done(12'h004, 0);
        run_req(4'd0, 3'd7, 12'h000, 4, 4'd0, 4'd2);

        a_w[0] = 16'hAB09; b_w[0] = 16'h0000;
`ifdef ALU_SEQ_DAA_EN
        exp_wr(0, 16'hAB15); exp_done(12'h095, 0);
        run_req(4'd8, 3'd3, 12'h001, 1, 4'd0, 4'd0);
`else
        exp_done(12'h001, 1);
        run_req(4'd8, 3'd3, 12'h001, 1, 4'd0, 4'd0);
`endif

        // Abort a 4-word ADD after its second write.
        for (int i = 0; i < 4; i++) begin a_w[i] = 16'(i + 1); b_w[i] = 16'h0000; end
        exp_wr(0, 16'h0001); exp_wr(1, 16'h0002);
        @(negedge clock);
        req_valid = 1'b1; req_mode = 4'd0; req_words = 3'd4; req_flags = 12'h000;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("abort_ready", int'(req_ready), 1);
        chk("abort_wr_valid", int'(wr_valid), 0);
        chk("abort_done_valid", int'(done_valid), 0);
        chk("abort_sb_empty", sb.size(), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);

        a_w[0] = 16'hFFFF; a_w[1] = 16'h0001; b_w[0] = 16'h0001; b_w[1] = 16'h0000;
        exp_wr(0, 16'h0000); exp_wr(1, 16'h0002); exp_done(12'h014, 0);
        run_req(4'd0, 3'd2, 12'h001, 2, 4'd0, 4'd2);

        repeat (2) @(negedge clock);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
